// File: rtl/wide_adder_chunk_sequencer.sv
`timescale 1ns/1ps
// Wide add/subtract sequencer: walks an external CHUNK-bit combinational adder
// across a WIDTH-bit operation, one chunk per cycle, rippling carry through a
// register between chunks. Request and result sides use valid/ready.
module wide_adder_chunk_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic [CHUNK-1:0] adder_a,
  output logic [CHUNK-1:0] adder_b,
  output logic             adder_cin,
  input  logic [CHUNK-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and adder-side drive; B is stored pre-inverted for subtraction
  // so RUN never needs to know which operation is in progress.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    valid_d     = valid_q;
    start_ready = 1'b0;
    adder_a     = '0;
    adder_b     = '0;
    adder_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        adder_cin = carry_q;
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDXW'(i)) begin
            adder_a                       = a_q[i*CHUNK +: CHUNK];
            adder_b                       = b_q[i*CHUNK +: CHUNK];
            result_d[i*CHUNK +: CHUNK]    = adder_sum;
          end
        end
        carry_d = adder_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = adder_cout;
          ovf_d   = adder_cout ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ adder_sum[CHUNK-1]);
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result_valid = valid_q;
  assign result       = result_q;
  assign cout         = cout_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_wide_adder_chunk_sequencer.sv
`timescale 1ns/1ps
// Bench for wide_adder_chunk_sequencer: table of directed add/sub vectors with
// hand-computed results, plus back-pressure and mid-run reset sequences.
module tb_wide_adder_chunk_sequencer;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        cin;
  logic        sub;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic        adder_cin;
  logic [15:0] adder_sum;
  logic        adder_cout;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result;
  logic        cout;
  logic        overflow;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] expResult;
    logic        expCout;
    logic        expOvf;
    logic [3:0]  expCin;
  } vec_t;

  vec_t vectors [8];

  wide_adder_chunk_sequencer #(
    .WIDTH(64),
    .CHUNK(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .sub         (sub),
    .adder_a     (adder_a),
    .adder_b     (adder_b),
    .adder_cin   (adder_cin),
    .adder_sum   (adder_sum),
    .adder_cout  (adder_cout),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow)
  );

  // External 16-bit combinational adder core.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'b0, adder_cin};

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequencer wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present a request in IDLE and return just after the accepting edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s, input string tag);
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    cin         = c;
    sub         = s;
    start_valid = 1'b1;
    checkOutput($sformatf("%s start_ready", tag), 64'(start_ready), 64'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Count cycles to result_valid and record adder_cin seen on each chunk.
  task automatic waitResult(output int cycles, output logic [3:0] cinSeen);
    cycles  = 0;
    cinSeen = 4'b0;
    @(negedge clk);
    while (!result_valid && cycles < 20) begin
      if (cycles < 4) cinSeen[cycles] = adder_cin;
      @(negedge clk);
      cycles++;
    end
  endtask

  // Take the result and confirm return to IDLE.
  task automatic releaseResult(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("%s valid cleared", tag), 64'(result_valid), 64'd0);
    checkOutput($sformatf("%s back to idle", tag), 64'(start_ready), 64'd1);
  endtask

  initial begin
    int         cycles;
    logic [3:0] cinSeen;
    string      tag;

    testsRun     = 0;
    testsFailed  = 0;
    reset        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    op_a         = '0;
    op_b         = '0;
    cin          = 1'b0;
    sub          = 1'b0;

    vectors[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 4'b1110};
    vectors[1] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'b0001};
    vectors[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1110};
    vectors[3] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 4'b1010};
    vectors[4] = '{64'h5, 64'h3, 1'b1, 1'b0, 64'h9, 1'b0, 1'b0, 4'b0001};
    vectors[5] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0, 4'b1111};
    vectors[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'b0001};
    vectors[7] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 4'b0000};

    // Reset state while reset is held.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset start_ready", 64'(start_ready), 64'd1);
    checkOutput("reset result_valid", 64'(result_valid), 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset cout", 64'(cout), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset adder_a", 64'(adder_a), 64'd0);
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, vectors[i].sub, tag);
      waitResult(cycles, cinSeen);
      checkOutput($sformatf("%s latency", tag), 64'(cycles), 64'd4);
      checkOutput($sformatf("%s result", tag), result, vectors[i].expResult);
      checkOutput($sformatf("%s cout", tag), 64'(cout), 64'(vectors[i].expCout));
      checkOutput($sformatf("%s overflow", tag), 64'(overflow), 64'(vectors[i].expOvf));
      checkOutput($sformatf("%s adder_cin per chunk", tag), 64'(cinSeen), 64'(vectors[i].expCin));
      checkOutput($sformatf("%s done start_ready", tag), 64'(start_ready), 64'd0);
      checkOutput($sformatf("%s done adder_cin", tag), 64'(adder_cin), 64'd0);
      releaseResult(tag);
    end

    // Back-pressure: result held while the consumer stalls and a request waits.
    applyStimulus(64'h1, 64'h2, 1'b0, 1'b0, "bp");
    waitResult(cycles, cinSeen);
    checkOutput("bp first result", result, 64'h3);
    op_a        = 64'h4;
    op_b        = 64'h4;
    cin         = 1'b0;
    sub         = 1'b0;
    start_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d result", c), result, 64'h3);
      checkOutput($sformatf("bp hold%0d start_ready", c), 64'(start_ready), 64'd0);
      checkOutput($sformatf("bp hold%0d result_valid", c), 64'(result_valid), 64'd1);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp idle start_ready", 64'(start_ready), 64'd1);
    checkOutput("bp idle result_valid", 64'(result_valid), 64'd0);
    checkOutput("bp idle result kept", result, 64'h3);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    waitResult(cycles, cinSeen);
    checkOutput("bp second latency", 64'(cycles), 64'd4);
    checkOutput("bp second result", result, 64'h8);
    releaseResult("bp");

    // Reset while the third chunk is on the adder.
    applyStimulus(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0, "rst");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst start_ready", 64'(start_ready), 64'd1);
    checkOutput("rst result_valid", 64'(result_valid), 64'd0);
    checkOutput("rst result", result, 64'd0);
    checkOutput("rst cout", 64'(cout), 64'd0);
    checkOutput("rst adder_a", 64'(adder_a), 64'd0);
    checkOutput("rst adder_cin", 64'(adder_cin), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst held%0d result_valid", c), 64'(result_valid), 64'd0);
    end
    reset = 1'b1;
    applyStimulus(64'h5, 64'h3, 1'b0, 1'b0, "post");
    waitResult(cycles, cinSeen);
    checkOutput("post latency", 64'(cycles), 64'd4);
    checkOutput("post result", result, 64'h8);
    checkOutput("post cout", 64'(cout), 64'd0);
    releaseResult("post");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wide_adder_chunk_sequencer.md
Name: wide_adder_chunk_sequencer

Overview:
Multi-cycle sequencer that performs WIDTH-bit add/subtract by driving an external CHUNK-bit combinational adder core one chunk per cycle. It feeds that core's operand and carry inputs, consumes its sum and carry outputs, and propagates carry between chunks. It sits between the execute-stage operand source and the adder core, with valid/ready handshakes on both the request side and the result side.

Parameters:
WIDTH, 64, total operand and result width; must be an integer multiple of CHUNK.
CHUNK, 16, adder core width in bits; NCHUNK = WIDTH/CHUNK, NCHUNK >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
start_valid  input  1  request valid.
start_ready  output  1  sequencer can accept a request.
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
cin  input  1  carry-in; ignored when sub=1.
sub  input  1  1 = A - B, computed as A + ~B + 1.
adder_a  output  CHUNK  chunk of A driven to the adder core.
adder_b  output  CHUNK  chunk of effective B driven to the adder core.
adder_cin  output  1  carry driven to the adder core.
adder_sum  input  CHUNK  adder core sum, combinational and valid in the same cycle.
adder_cout  input  1  adder core carry-out, same cycle.
result_valid  output  1  result available.
result_ready  input  1  consumer accepts the result.
result  output  WIDTH  final sum.
cout  output  1  carry out of the MSB.
overflow  output  1  signed overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; chunk index, carry register, operand registers and result all clear to 0.
  - result_valid=0, cout=0, overflow=0, start_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid=1, at the clock edge:
    - latch op_a into a_reg;
    - latch op_b, or ~op_b when sub=1, into b_reg;
    - carry <= (sub ? 1 : cin); idx <= 0; go to RUN.
- RUN:
  - start_ready=0.
  - adder_a=a_reg[idx*CHUNK +: CHUNK], adder_b=b_reg[idx*CHUNK +: CHUNK], adder_cin=carry.
  - Each edge: result[idx*CHUNK +: CHUNK] <= adder_sum; carry <= adder_cout; idx <= idx+1.
  - On the edge where idx=NCHUNK-1:
    - cout <= adder_cout;
    - overflow <= adder_cout XOR (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ adder_sum[CHUNK-1]), the carry into the MSB;
    - result_valid <= 1; go to DONE.
- DONE:
  - start_ready=0; result, cout and overflow held stable.
  - On result_ready=1: result_valid <= 0; go to IDLE.
  - A new request is accepted no earlier than the cycle after the result is taken; there is no overlap.
- Adder-side outputs (adder_a, adder_b, adder_cin) are 0 in IDLE and DONE.
- Latency: request accepted at edge k; result_valid=1 after edge k+NCHUNK. Throughput is one operation per NCHUNK+2 cycles minimum.
- result keeps its last value after hand-off until the next operation overwrites it chunk by chunk.
- start_valid while start_ready=0 is ignored; the requester must hold its request.
- Reset during RUN or DONE aborts the operation; no result_valid pulse is emitted.

Test Plan:
- WIDTH=64, CHUNK=16, op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0x1, cin=0, sub=0 -> result=0, cout=1, overflow=0, result_valid exactly 4 cycles after accept.
- op_a=0, op_b=1, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0; adder_cin=1 observed on chunk 0.
- op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=1, sub=0 -> result=0x8000_0000_0000_0000, overflow=1, cout=0.
- op_a=0x0000_FFFF_0000_FFFF, op_b=0x0000_0001_0000_0001 -> result=0x0001_0000_0001_0000. Check adder_cin per chunk: 0, 1, 0, 1.
- Hold result_ready=0 for 5 cycles after result_valid with start_valid=1 -> result stable, start_ready=0, no new accept. Release -> IDLE next cycle, then the new request is accepted.
- Assert reset while idx=2 in RUN -> outputs immediately at reset values. After release, a fresh 0x5+0x3 request yields result=0x8.
